// File: rtl/gate_bank_reg.sv
// rtl/gate_bank_reg.sv - registered bank of and2, and16 and 1-to-2 dmux built from nand2
//
// Purpose:
//   Evaluates three gate primitives combinationally and captures their results
//   into output registers on an enable strobe. A valid flag goes high for the
//   cycle after each capture.
//
// Optional feature macro: GATE_BANK_COMB_TAP_EN
//   When defined, the unregistered core values are exported on
//   y_and_c, y16_and_c, a_out_c and b_out_c. Registered behaviour is the same
//   in both builds.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset, overrides en
//   en         in   1   capture strobe
//   a, b       in   1   and2 operands
//   a16, b16   in   16  and16 operands
//   in         in   1   dmux data input
//   sel        in   1   dmux select (0 -> a_out, 1 -> b_out)
//   y_and      out  1   registered a & b
//   y16_and    out  16  registered a16 & b16
//   a_out      out  1   registered in & ~sel
//   b_out      out  1   registered in & sel
//   out_valid  out  1   high for the cycle after a capture
//   y_and_c, y16_and_c, a_out_c, b_out_c (macro builds only): unregistered core

module gate_bank_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        a,
  input  logic        b,
  input  logic [15:0] a16,
  input  logic [15:0] b16,
  input  logic        in,
  input  logic        sel,
  output logic        y_and,
  output logic [15:0] y16_and,
  output logic        a_out,
  output logic        b_out,
  output logic        out_valid
`ifdef GATE_BANK_COMB_TAP_EN
  ,
  output logic        y_and_c,
  output logic [15:0] y16_and_c,
  output logic        a_out_c,
  output logic        b_out_c
`endif
);

  // Every gate in the core reduces to this single primitive.
  function automatic logic f_nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  function automatic logic f_not(input logic x);
    return f_nand2(x, x);
  endfunction

  function automatic logic f_and2(input logic x, input logic y);
    return f_not(f_nand2(x, y));
  endfunction

  logic        w_and2;
  logic [15:0] w_and16;
  logic        w_sel_n;
  logic        w_dmux_a;
  logic        w_dmux_b;

  logic        r_y_and;
  logic [15:0] r_y16_and;
  logic        r_a_out;
  logic        r_b_out;
  logic        r_out_valid;

  assign w_and2 = f_and2(a, b);

  // Sixteen independent and2 paths; no bit sees any other bit.
  for (genvar g = 0; g < 16; g++) begin : g_and16
    assign w_and16[g] = f_and2(a16[g], b16[g]);
  end

  // sel steers 'in' to exactly one leg, so both legs are 0 when in = 0.
  assign w_sel_n  = f_not(sel);
  assign w_dmux_a = f_and2(in, w_sel_n);
  assign w_dmux_b = f_and2(in, sel);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_and     <= 1'b0;
      r_y16_and   <= 16'h0000;
      r_a_out     <= 1'b0;
      r_b_out     <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (en) begin
      r_y_and     <= w_and2;
      r_y16_and   <= w_and16;
      r_a_out     <= w_dmux_a;
      r_b_out     <= w_dmux_b;
      r_out_valid <= 1'b1;
    end else begin
      // Data registers hold; the valid flag only marks fresh captures.
      r_out_valid <= 1'b0;
    end
  end

  assign y_and     = r_y_and;
  assign y16_and   = r_y16_and;
  assign a_out     = r_a_out;
  assign b_out     = r_b_out;
  assign out_valid = r_out_valid;

`ifdef GATE_BANK_COMB_TAP_EN
  assign y_and_c   = w_and2;
  assign y16_and_c = w_and16;
  assign a_out_c   = w_dmux_a;
  assign b_out_c   = w_dmux_b;
`endif

endmodule

// File: tb/tb_gate_bank_reg.sv
// tb/tb_gate_bank_reg.sv - self-checking bench for gate_bank_reg

module tb_gate_bank_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        a;
  logic        b;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        in;
  logic        sel;
  logic        y_and;
  logic [15:0] y16_and;
  logic        a_out;
  logic        b_out;
  logic        out_valid;
`ifdef GATE_BANK_COMB_TAP_EN
  logic        y_and_c;
  logic [15:0] y16_and_c;
  logic        a_out_c;
  logic        b_out_c;
`endif

  always #5 clk = ~clk;

  gate_bank_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .a         (a),
    .b         (b),
    .a16       (a16),
    .b16       (b16),
    .in        (in),
    .sel       (sel),
    .y_and     (y_and),
    .y16_and   (y16_and),
    .a_out     (a_out),
    .b_out     (b_out),
    .out_valid (out_valid)
`ifdef GATE_BANK_COMB_TAP_EN
    ,
    .y_and_c   (y_and_c),
    .y16_and_c (y16_and_c),
    .a_out_c   (a_out_c),
    .b_out_c   (b_out_c)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the registered outputs should hold.
  logic        m_y;
  logic [15:0] m_y16;
  logic        m_a;
  logic        m_b;
  logic        m_v;

  typedef struct {
    string       name;
    logic        a;
    logic        b;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        in;
    logic        sel;
    logic        exp_y;
    logic [15:0] exp_y16;
    logic        exp_a;
    logic        exp_b;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied,
  // then let the DUT take the same edge and settle.
  task automatic tick();
    if (!rst_n) begin
      m_y = 1'b0; m_y16 = 16'h0000; m_a = 1'b0; m_b = 1'b0; m_v = 1'b0;
    end else if (en) begin
      m_y   = a & b;
      m_y16 = a16 & b16;
      m_a   = in && !sel;
      m_b   = in && sel;
      m_v   = 1'b1;
    end else begin
      m_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".y_and"},     {15'd0, y_and},     {15'd0, m_y});
    chk({tag, ".y16_and"},   y16_and,            m_y16);
    chk({tag, ".a_out"},     {15'd0, a_out},     {15'd0, m_a});
    chk({tag, ".b_out"},     {15'd0, b_out},     {15'd0, m_b});
    chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, m_v});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".y_and"},     {15'd0, y_and},     16'h0000);
    chk({tag, ".y16_and"},   y16_and,            16'h0000);
    chk({tag, ".a_out"},     {15'd0, a_out},     16'h0000);
    chk({tag, ".b_out"},     {15'd0, b_out},     16'h0000);
    chk({tag, ".out_valid"}, {15'd0, out_valid}, 16'h0000);
  endtask

  task automatic randomize_inputs();
    a   = 1'($urandom);
    b   = 1'($urandom);
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    in  = 1'($urandom);
    sel = 1'($urandom);
  endtask

  initial begin
    logic [15:0] held_y16;

    vecs[0]  = '{"and2_00",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{"and2_01",  1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{"and2_10",  1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{"and2_11",  1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{"and16_f0", 1'b0, 1'b0, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{"and16_12", 1'b0, 1'b0, 16'h1234, 16'hFEDC, 1'b0, 1'b0, 1'b0, 16'h1214, 1'b0, 1'b0};
    vecs[6]  = '{"and16_80", 1'b0, 1'b0, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0};
    vecs[7]  = '{"and16_aa", 1'b0, 1'b0, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{"dmux_00",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{"dmux_01",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{"dmux_10",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{"dmux_11",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};

    // Reset held over two edges with every input driving ones.
    rst_n = 1'b0; en = 1'b1;
    a = 1'b1; b = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; in = 1'b1; sel = 1'b1;
    #1;
    tick();
    tick();
    chk_zero("reset");

    // First capture after release.
    rst_n = 1'b1;
    tick();
    chk("post_rst.y_and",     {15'd0, y_and},     16'h0001);
    chk("post_rst.y16_and",   y16_and,            16'hFFFF);
    chk("post_rst.a_out",     {15'd0, a_out},     16'h0000);
    chk("post_rst.b_out",     {15'd0, b_out},     16'h0001);
    chk("post_rst.out_valid", {15'd0, out_valid}, 16'h0001);

    // Directed vectors, one capture each.
    for (int i = 0; i < 12; i++) begin
      en  = 1'b1;
      a   = vecs[i].a;   b   = vecs[i].b;
      a16 = vecs[i].a16; b16 = vecs[i].b16;
      in  = vecs[i].in;  sel = vecs[i].sel;
      tick();
      chk({vecs[i].name, ".y_and"},     {15'd0, y_and},     {15'd0, vecs[i].exp_y});
      chk({vecs[i].name, ".y16_and"},   y16_and,            vecs[i].exp_y16);
      chk({vecs[i].name, ".a_out"},     {15'd0, a_out},     {15'd0, vecs[i].exp_a});
      chk({vecs[i].name, ".b_out"},     {15'd0, b_out},     {15'd0, vecs[i].exp_b});
      chk({vecs[i].name, ".out_valid"}, {15'd0, out_valid}, 16'h0001);
    end

    // Hold: capture ones, then drop en and toggle inputs.
    en = 1'b1; a = 1'b1; b = 1'b1; a16 = 16'hC3A5; b16 = 16'hFFFF; in = 1'b1; sel = 1'b0;
    tick();
    chk("hold_cap.y_and", {15'd0, y_and}, 16'h0001);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = ~a; b = ~b; a16 = ~a16; b16 = ~b16; in = ~in; sel = ~sel;
      tick();
      chk("hold.y_and",     {15'd0, y_and},     16'h0001);
      chk("hold.y16_and",   y16_and,            16'hC3A5);
      chk("hold.a_out",     {15'd0, a_out},     16'h0001);
      chk("hold.b_out",     {15'd0, b_out},     16'h0000);
      chk("hold.out_valid", {15'd0, out_valid}, 16'h0000);
    end
    rst_n = 1'b0;
    tick();
    chk_zero("hold_rst");
    rst_n = 1'b1;

    // Reset wins over en mid-stream.
    en = 1'b1; a = 1'b1; b = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; in = 1'b1; sel = 1'b1;
    tick();
    chk("stream.y16_and", y16_and, 16'hFFFF);
    rst_n = 1'b0;
    tick();
    chk_zero("stream_rst");
    rst_n = 1'b1;

    // 1000 random captures against the model.
    for (int i = 0; i < 1000; i++) begin
      randomize_inputs();
      en = 1'b1;
      tick();
      chk_model("rand_cap");
    end

    // Mixed random en / reset traffic.
    for (int i = 0; i < 500; i++) begin
      randomize_inputs();
      en    = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 15) != 0);
      tick();
      chk_model("rand_mix");
    end
    rst_n = 1'b1;

`ifdef GATE_BANK_COMB_TAP_EN
    en = 1'b1; a16 = 16'h1234; b16 = 16'hFFFF;
    tick();
    held_y16 = 16'h1234;
    en  = 1'b0;
    b16 = 16'h0F0F;
    a16 = 16'h00FF;
    #1;
    chk("tap.y16_and_c", y16_and_c, 16'h000F);
    chk("tap.y16_and",   y16_and,   held_y16);
`else
    held_y16 = 16'h0000;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
